ahb_arbiter: RTL and testbench
==============================

AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of requesting masters; taken from param_pkg.
REQ-002 Parameter DEFAULT_MASTER, default 0, index granted when no master requests.
REQ-003 Hclk  in  1  bus clock; all state updates on its rising edge.
REQ-004 Hresetn  in  1  asynchronous, active-low reset.
REQ-005 Hbusreq  in  NUM_MASTERS  per-master bus request.
REQ-006 Hlock  in  NUM_MASTERS  per-master locked-transfer request.
REQ-007 Htrans  in  2  transfer type of the current address-phase owner (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-008 Hburst  in  3  burst type of the current address-phase owner.
REQ-009 Hready  in  1  global ready, from the slave-to-master mux.
REQ-010 Hgrant  out  NUM_MASTERS  one-hot grant.
REQ-011 Hmaster  out  MASTER_ID_W  index of the address-phase owner.
REQ-012 Hmastlock  out  1  current transfer is part of a locked sequence.

Function
REQ-013 Hgrant is always exactly one-hot.
REQ-014 All state (grant, Hmaster, Hmastlock, beat counter, priority pointer) changes only on Hclk edges where Hready=1.
REQ-015 An arbitration point occurs when Hready=1 and the bus is not held (REQ-019, REQ-020).
- At that point the winner is chosen from Hbusreq.
- Hgrant updates at that edge.
REQ-016 Hmaster and Hmastlock take the granted index and Hlock[granted] at the next Hready=1 edge after the grant change, i.e. one-transfer latency.
REQ-017 No Hbusreq asserted at an arbitration point -> grant DEFAULT_MASTER.
REQ-018 Beat counter:
- Loaded on NONSEQ with Hready=1: SINGLE/INCR=0, INCR4/WRAP4=3, INCR8/WRAP8=7, INCR16/WRAP16=15.
- Decremented on SEQ with Hready=1; saturates at 0.
- BUSY leaves it unchanged.
REQ-019 Burst hold: grant is held while counter>1 or the counter is reloaded to a non-zero value at the same edge.
- Re-arbitration is permitted in the address phase of the last beat (counter<=1), and on IDLE.
REQ-020 Lock hold: grant is held while Hlock[granted]=1, regardless of burst state; a held grant does not update the pointer.
REQ-021 Undefined-length INCR bursts are never held; re-arbitration is permitted at every Hready=1 edge.
REQ-022 The requester already granted keeps the grant if it wins arbitration; no idle cycle is inserted.
REQ-023 Hready=0 freezes every output and all internal state, including mid-burst and under lock.
REQ-024 Winner deasserts Hbusreq while held (burst or lock) -> grant still held until REQ-019/REQ-020 release.

Reset
REQ-025 Hresetn low at any time asynchronously forces:
- Hgrant = one-hot DEFAULT_MASTER; Hmaster = DEFAULT_MASTER; Hmastlock = 0.
- Beat counter = 0; round-robin pointer = DEFAULT_MASTER.
REQ-026 Reset mid-burst or mid-lock abandons the sequence; the first edge after release with Hready=1 is an arbitration point.

Configuration
REQ-027 Macro ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest requesting index wins; the pointer is unused.
- Undefined: round-robin. The search starts at the index after the last granted master and wraps from NUM_MASTERS-1 to 0. The pointer updates to the winner at each arbitration point that changes the grant.

Structure
REQ-028 param_pkg holds:
- NUM_MASTERS; MASTER_ID_W = $clog2(NUM_MASTERS).
- htrans_t and hburst_t enum typedefs.
REQ-029 Winner selection is a combinational sub-module, arb_rr_picker (request vector + pointer -> one-hot winner); the sequencing state stays in ahb_arbiter.

Verification
REQ-030 Reset then no requests -> Hgrant=0001, Hmaster=0, Hmastlock=0.
REQ-031 Round-robin, Hbusreq=1111, singles, Hready=1 -> grant order M1, M2, M3, M0, M1 on successive edges; Hmaster lags by one edge.
REQ-032 Burst hold: M2 granted, issues INCR4, M1 requests -> grant stays M2 for beats 1-3, moves to M1 at the beat-4 address phase.
- Inserting Hready=0 for 3 cycles mid-burst -> no output changes.
REQ-033 Lock: M3 asserts Hlock with a SINGLE and Hbusreq=1111 -> grant held at M3 until Hlock drops; Hmastlock=1 for those transfers.
REQ-034 Reset mid-WRAP8 at beat 5 -> outputs return to reset values immediately; the next Hready=1 edge grants the round-robin winner starting from M1 (M0 under ARB_FIXED_PRIORITY_EN).

Source files
------------

// File: rtl/param_pkg.sv
// Shared AHB arbiter configuration and bus encodings.
package param_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int MASTER_ID_W = $clog2(NUM_MASTERS);
    localparam int BEAT_W      = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    // Beats remaining after the first one; undefined-length INCR counts as 0.
    function automatic logic [BEAT_W-1:0] burst_reload(hburst_t b);
        case (b)
            HBURST_WRAP4,  HBURST_INCR4:  return BEAT_W'(3);
            HBURST_WRAP8,  HBURST_INCR8:  return BEAT_W'(7);
            HBURST_WRAP16, HBURST_INCR16: return BEAT_W'(15);
            default:                      return '0;
        endcase
    endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational winner select: first requester after ptr, wrapping.
// With ARB_FIXED_PRIORITY_EN defined the lowest requesting index wins instead.
module arb_rr_picker #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    win
);

`ifdef ARB_FIXED_PRIORITY_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign win        = req & (~req + 1'b1);
`else
    // Distance of master j from the search start (ptr+1); smallest requesting distance wins.
    always_comb begin
        int d;
        int best_d;
        int best_j;
        win    = '0;
        d      = 0;
        best_d = N;
        best_j = 0;
        for (int j = 0; j < N; j++) begin
            d = (j + N - int'(ptr) - 1) % N;
            if (req[j] && d < best_d) begin
                best_d = d;
                best_j = j;
            end
        end
        for (int j = 0; j < N; j++)
            win[j] = (best_d < N) && (j == best_j);
    end
`endif

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: burst- and lock-aware grant sequencing around arb_rr_picker.
// Define ARB_FIXED_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module ahb_arbiter
    import param_pkg::*;
#(
    parameter int  NUM_MASTERS    = param_pkg::NUM_MASTERS,
    parameter int  DEFAULT_MASTER = 0,
    localparam int ID_W           = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    input  logic [NUM_MASTERS-1:0] Hbusreq,
    input  logic [NUM_MASTERS-1:0] Hlock,
    input  logic [1:0]             Htrans,
    input  logic [2:0]             Hburst,
    input  logic                   Hready,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [ID_W-1:0]        Hmaster,
    output logic                   Hmastlock
);

    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [ID_W-1:0]        DEF_ID    = ID_W'(DEFAULT_MASTER);

    htrans_t                trans;
    hburst_t                burst;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [BEAT_W-1:0]      beat_nxt;
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        gnt_id;
    logic [ID_W-1:0]        nxt_id;
    logic [NUM_MASTERS-1:0] win;
    logic [NUM_MASTERS-1:0] gnt_nxt;
    logic                   burst_hold;
    logic                   lock_hold;
    logic                   arb_pt;

    assign trans = htrans_t'(Htrans);
    assign burst = hburst_t'(Hburst);

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (Hgrant[i]) gnt_id = ID_W'(i);
    end

    always_comb begin
        beat_nxt = beat_cnt;
        case (trans)
            HTRANS_NONSEQ: beat_nxt = burst_reload(burst);
            HTRANS_SEQ:    if (beat_cnt != '0) beat_nxt = beat_cnt - 1'b1;
            default:       ;
        endcase
    end

    // Release in the last beat's address phase; the reload term covers the first beat.
    assign burst_hold = (trans != HTRANS_IDLE) &&
                        ((beat_cnt > BEAT_W'(1)) || (trans == HTRANS_NONSEQ && beat_nxt != '0));
    assign lock_hold  = Hlock[gnt_id];
    assign arb_pt     = !(burst_hold || lock_hold);

    arb_rr_picker #(
        .N    (NUM_MASTERS),
        .ID_W (ID_W)
    ) u_picker (
        .req (Hbusreq),
        .ptr (ptr),
        .win (win)
    );

    assign gnt_nxt = (|Hbusreq) ? win : DEF_GRANT;

    always_comb begin
        nxt_id = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (gnt_nxt[i]) nxt_id = ID_W'(i);
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Hgrant    <= DEF_GRANT;
            Hmaster   <= DEF_ID;
            Hmastlock <= 1'b0;
            beat_cnt  <= '0;
            ptr       <= DEF_ID;
        end else if (Hready) begin
            Hmaster   <= gnt_id;
            Hmastlock <= Hlock[gnt_id];
            beat_cnt  <= beat_nxt;
            if (arb_pt) begin
                Hgrant <= gnt_nxt;
                if (gnt_nxt != Hgrant) ptr <= nxt_id;
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: per-cycle comparison against a behavioural model
// plus hand-computed literal expectations for the key scenarios.
module tb_ahb_arbiter;

    localparam int N = 4;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3, B_WRAP8 = 3'd4;

    logic         Hclk    = 1'b0;
    logic         Hresetn = 1'b1;
    logic [N-1:0] Hbusreq = '0;
    logic [N-1:0] Hlock   = '0;
    logic [1:0]   Htrans  = IDLE;
    logic [2:0]   Hburst  = B_SINGLE;
    logic         Hready  = 1'b1;
    logic [N-1:0] Hgrant;
    logic [1:0]   Hmaster;
    logic         Hmastlock;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hbusreq   (Hbusreq),
        .Hlock     (Hlock),
        .Htrans    (Htrans),
        .Hburst    (Hburst),
        .Hready    (Hready),
        .Hgrant    (Hgrant),
        .Hmaster   (Hmaster),
        .Hmastlock (Hmastlock)
    );

    always #5 Hclk = ~Hclk;

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, exp, $time);
    endtask

    // Behavioural model: master indices as integers, remaining beats as a plain count.
    int m_gnt  = 0;
    int m_mst  = 0;
    int m_last = 0;
    int m_cnt  = 0;
    bit m_lck  = 1'b0;

    function automatic int beats_left(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 3;
            3'd4, 3'd5: return 7;
            3'd6, 3'd7: return 15;
            default:    return 0;
        endcase
    endfunction

    function automatic int pick(input logic [N-1:0] req, input int last);
        int c;
        if (req == '0) return 0;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < N; k++) if (req[k]) return k;
`else
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (req[c]) return c;
        end
`endif
        return 0;
    endfunction

    always @(posedge Hclk or negedge Hresetn) begin
        bit held;
        int w;
        int ncnt;
        if (!Hresetn) begin
            m_gnt  <= 0;
            m_mst  <= 0;
            m_last <= 0;
            m_cnt  <= 0;
            m_lck  <= 1'b0;
        end else if (Hready) begin
            held = Hlock[m_gnt] ||
                   (Htrans != IDLE && (m_cnt > 1 || (Htrans == NS && beats_left(Hburst) > 0)));
            ncnt = m_cnt;
            if (Htrans == NS) ncnt = beats_left(Hburst);
            else if (Htrans == SEQ && m_cnt > 0) ncnt = m_cnt - 1;
            m_mst <= m_gnt;
            m_lck <= Hlock[m_gnt];
            m_cnt <= ncnt;
            if (!held) begin
                w = pick(Hbusreq, m_last);
                if (w != m_gnt) m_last <= w;
                m_gnt <= w;
            end
        end
    end

    always @(negedge Hclk) begin
        if (chk_en) begin
            check("onehot", $countones(Hgrant), 1);
            check("model_gnt", int'(Hgrant), 1 << m_gnt);
            check("model_mst", int'(Hmaster), m_mst);
            check("model_lck", int'(Hmastlock), int'(m_lck));
        end
    end

    task automatic step(input logic [N-1:0] req, input logic [N-1:0] lck,
                        input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        Hbusreq = req;
        Hlock   = lck;
        Htrans  = tr;
        Hburst  = bu;
        Hready  = rdy;
        @(posedge Hclk);
        #1;
    endtask

`ifdef ARB_FIXED_PRIORITY_EN
    int rr_g[5] = '{1, 1, 1, 1, 1};
    int rr_m[5] = '{0, 0, 0, 0, 0};
    localparam int INCR_G1 = 1;
    localparam int POST_RST_G = 1;
`else
    int rr_g[5] = '{2, 4, 8, 1, 2};
    int rr_m[5] = '{0, 1, 2, 3, 0};
    localparam int INCR_G1 = 2;
    localparam int POST_RST_G = 2;
`endif

    initial begin
        #1 Hresetn = 1'b0;
        repeat (2) @(posedge Hclk);
        #1;
        chk_en = 1'b1;
        check("rst_gnt", int'(Hgrant), 1);
        check("rst_mst", int'(Hmaster), 0);
        check("rst_lck", int'(Hmastlock), 0);
        Hresetn = 1'b1;

        step(4'b0000, 4'b0000, IDLE, B_SINGLE, 1'b1);
        check("idle_default", int'(Hgrant), 1);

        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b0000, NS, B_SINGLE, 1'b1);
            check("rr_gnt", int'(Hgrant), rr_g[k]);
            check("rr_mst", int'(Hmaster), rr_m[k]);
        end

        // INCR4 from M2; M2 drops its request mid-burst, M1 waits.
        step(4'b0100, 4'b0000, IDLE, B_SINGLE, 1'b1);
        check("burst_pre_gnt", int'(Hgrant), 4);
        step(4'b0100, 4'b0000, IDLE, B_SINGLE, 1'b1);
        check("burst_pre_mst", int'(Hmaster), 2);
        step(4'b0110, 4'b0000, NS, B_INCR4, 1'b1);
        check("burst_b1", int'(Hgrant), 4);
        repeat (3) begin
            step(4'b0010, 4'b0000, SEQ, B_INCR4, 1'b0);
            check("stall_gnt", int'(Hgrant), 4);
            check("stall_mst", int'(Hmaster), 2);
        end
        step(4'b0010, 4'b0000, SEQ, B_INCR4, 1'b1);
        check("burst_b2", int'(Hgrant), 4);
        step(4'b0010, 4'b0000, SEQ, B_INCR4, 1'b1);
        check("burst_b3", int'(Hgrant), 4);
        step(4'b0010, 4'b0000, SEQ, B_INCR4, 1'b1);
        check("burst_b4_gnt", int'(Hgrant), 2);
        check("burst_b4_mst", int'(Hmaster), 2);
        step(4'b0010, 4'b0000, IDLE, B_SINGLE, 1'b1);
        check("burst_after_mst", int'(Hmaster), 1);

        // Locked sequence by M3 against full contention.
        step(4'b1000, 4'b1000, IDLE, B_SINGLE, 1'b1);
        check("lock_gnt0", int'(Hgrant), 8);
        check("lock_lck0", int'(Hmastlock), 0);
        step(4'b1111, 4'b1000, IDLE, B_SINGLE, 1'b1);
        check("lock_gnt1", int'(Hgrant), 8);
        check("lock_mst1", int'(Hmaster), 3);
        check("lock_lck1", int'(Hmastlock), 1);
        repeat (2) begin
            step(4'b1111, 4'b1000, NS, B_SINGLE, 1'b1);
            check("lock_gnt_hold", int'(Hgrant), 8);
            check("lock_lck_hold", int'(Hmastlock), 1);
        end
        step(4'b1111, 4'b0000, NS, B_SINGLE, 1'b1);
        check("unlock_gnt", int'(Hgrant), 1);
        check("unlock_mst", int'(Hmaster), 3);
        check("unlock_lck", int'(Hmastlock), 0);

        // Undefined-length INCR is never held.
        step(4'b1111, 4'b0000, NS, B_INCR, 1'b1);
        check("incr_gnt", int'(Hgrant), INCR_G1);
        step(4'b1111, 4'b0000, SEQ, B_INCR, 1'b1);
        step(4'b1111, 4'b0000, BUSY, B_INCR, 1'b1);

        // WRAP8 by M2, reset during the beat-5 address phase.
        step(4'b0100, 4'b0000, IDLE, B_SINGLE, 1'b1);
        step(4'b0100, 4'b0000, IDLE, B_SINGLE, 1'b1);
        check("wrap_pre_mst", int'(Hmaster), 2);
        step(4'b1111, 4'b0000, NS, B_WRAP8, 1'b1);
        repeat (3) step(4'b1111, 4'b0000, SEQ, B_WRAP8, 1'b1);
        check("wrap_hold", int'(Hgrant), 4);
        #2 Hresetn = 1'b0;
        #1;
        check("midrst_gnt", int'(Hgrant), 1);
        check("midrst_mst", int'(Hmaster), 0);
        check("midrst_lck", int'(Hmastlock), 0);
        #3 Hresetn = 1'b1;
        step(4'b1111, 4'b0000, IDLE, B_SINGLE, 1'b1);
        check("postrst_gnt", int'(Hgrant), POST_RST_G);
        check("postrst_mst", int'(Hmaster), 0);
        step(4'b0000, 4'b0000, IDLE, B_SINGLE, 1'b1);
        step(4'b0000, 4'b0000, IDLE, B_SINGLE, 1'b1);
        check("final_default", int'(Hgrant), 1);

        @(negedge Hclk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench did not complete");
    end

endmodule
